// File: rtl/game_pkg.sv
// Shared game-wide types and constants: turn phases, special keycodes, player indices.
package game_pkg;

    typedef enum logic [1:0] {
        AIM    = 2'd0,
        FLIGHT = 2'd1,
        SETTLE = 2'd2
    } phase_e;

    localparam logic [7:0] KEY_PAUSE = 8'h13;
    localparam logic [7:0] KEY_NONE  = 8'h00;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings an asynchronous frame strobe into the clk domain and emits a one-clk
// registered tick for each rising edge (visible 3 clk after the strobe edge).
module frame_tick (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/turn_controller.sv
// Two-player turn sequencer: AIM (timed, pausable) -> FLIGHT -> SETTLE -> next player's AIM,
// gating the keyboard to whichever player currently owns the turn.
module turn_controller
    import game_pkg::*;
#(
    parameter int TURN_SECONDS   = 30,
    parameter int FRAMES_PER_SEC = 60,
    parameter int SETTLE_FRAMES  = 60,
    parameter int FLIGHT_TIMEOUT = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       bomb_busy_p1,
    input  logic       bomb_busy_p2,
    output logic [7:0] keycode_p1,
    output logic [7:0] keycode_p2,
    output logic       active_player,
    output logic [1:0] phase,
    output logic [5:0] seconds_left,
    output logic       paused,
    output logic       turn_start
);

    localparam int CNT_MAX = max3(FRAMES_PER_SEC, SETTLE_FRAMES, FLIGHT_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEC_LAST    = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_TIMEOUT - 1);
    localparam logic [5:0]       SECS_INIT   = 6'(TURN_SECONDS);

    logic tick;

    frame_tick u_frame_tick (
        .clk      (clk),
        .reset    (reset),
        .async_in (frame_clk),
        .tick     (tick)
    );

    phase_e           phase_q, phase_d;
    logic             active_q, active_d;
    logic [5:0]       seconds_q, seconds_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       kp1_q, kp1_d;
    logic [7:0]       kp2_q, kp2_d;
    logic             turn_start_q, turn_start_d;
    logic             busy_prev_q, busy_prev_d;
    logic             key_prev_q, key_prev_d;

    logic busy_now;
    logic busy_rise;
    logic busy_fall;
    logic key_pause;
    logic pause_press;
    logic gate_open;

    always_comb begin
        busy_now    = (active_q == PLAYER_2) ? bomb_busy_p2 : bomb_busy_p1;
        busy_rise   = busy_now & ~busy_prev_q;
        busy_fall   = ~busy_now & busy_prev_q;
        key_pause   = (keycode == KEY_PAUSE);
        pause_press = key_pause & ~key_prev_q;

        phase_d      = phase_q;
        active_d     = active_q;
        seconds_d    = seconds_q;
        paused_d     = paused_q;
        cnt_d        = cnt_q;
        turn_start_d = 1'b0;

        case (phase_q)
            AIM: begin
                if (paused_q) begin
                    // Everything but the pause key is frozen while paused.
                    if (pause_press) begin
                        paused_d = 1'b0;
                    end
                end else begin
                    if (busy_rise) begin
                        phase_d = FLIGHT;
                        cnt_d   = CNT_ZERO;
                    end else if (tick) begin
                        if (cnt_q == SEC_LAST) begin
                            cnt_d = CNT_ZERO;
                            if (seconds_q <= 6'd1) begin
                                seconds_d = 6'd0;
                                phase_d   = SETTLE;
                            end else begin
                                seconds_d = seconds_q - 6'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    // A press on the same clk the turn leaves AIM is dropped.
                    if (phase_d == AIM && pause_press) begin
                        paused_d = 1'b1;
                    end
                end
            end
            FLIGHT: begin
                if (busy_fall || (tick && cnt_q == FLIGHT_LAST)) begin
                    phase_d = SETTLE;
                    cnt_d   = CNT_ZERO;
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        phase_d      = AIM;
                        active_d     = ~active_q;
                        seconds_d    = SECS_INIT;
                        paused_d     = 1'b0;
                        cnt_d        = CNT_ZERO;
                        turn_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                phase_d = AIM;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Track the next owner's busy level so a level already high at turn entry never counts as a launch.
        busy_prev_d = (active_d == PLAYER_2) ? bomb_busy_p2 : bomb_busy_p1;
        key_prev_d  = key_pause;

        gate_open = (phase_d == AIM) && !paused_d;
        kp1_d     = (gate_open && active_d == PLAYER_1) ? keycode : KEY_NONE;
        kp2_d     = (gate_open && active_d == PLAYER_2) ? keycode : KEY_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= AIM;
            active_q     <= PLAYER_1;
            seconds_q    <= SECS_INIT;
            paused_q     <= 1'b0;
            cnt_q        <= CNT_ZERO;
            kp1_q        <= KEY_NONE;
            kp2_q        <= KEY_NONE;
            turn_start_q <= 1'b0;
            busy_prev_q  <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            active_q     <= active_d;
            seconds_q    <= seconds_d;
            paused_q     <= paused_d;
            cnt_q        <= cnt_d;
            kp1_q        <= kp1_d;
            kp2_q        <= kp2_d;
            turn_start_q <= turn_start_d;
            busy_prev_q  <= busy_prev_d;
            key_prev_q   <= key_prev_d;
        end
    end

    assign keycode_p1    = kp1_q;
    assign keycode_p2    = kp2_q;
    assign active_player = active_q;
    assign phase         = phase_q;
    assign seconds_left  = seconds_q;
    assign paused        = paused_q;
    assign turn_start    = turn_start_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized scoreboard bench for turn_controller: a tick-counting reference model
// predicts every clk's outputs, a negedge monitor compares them against the DUT.
module tb_turn_controller;
    import game_pkg::*;

    localparam int TURN     = 30;
    localparam int FPS      = 60;
    localparam int SETTLE_F = 60;
    localparam int TIMEOUT  = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       bomb_busy_p1 = 1'b0;
    logic       bomb_busy_p2 = 1'b0;
    logic [7:0] keycode_p1, keycode_p2;
    logic       active_player;
    logic [1:0] phase;
    logic [5:0] seconds_left;
    logic       paused;
    logic       turn_start;

    turn_controller #(
        .TURN_SECONDS   (TURN),
        .FRAMES_PER_SEC (FPS),
        .SETTLE_FRAMES  (SETTLE_F),
        .FLIGHT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .bomb_busy_p1  (bomb_busy_p1),
        .bomb_busy_p2  (bomb_busy_p2),
        .keycode_p1    (keycode_p1),
        .keycode_p2    (keycode_p2),
        .active_player (active_player),
        .phase         (phase),
        .seconds_left  (seconds_left),
        .paused        (paused),
        .turn_start    (turn_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ts_seen = 0;
    int exp_ts = 0;

    logic [26:0] exp_q[$];
    logic [26:0] mon_exp;
    wire  [26:0] dut_vec = {keycode_p1, keycode_p2, active_player, phase, seconds_left, paused, turn_start};

    // Reference model: time is counted in whole frame ticks per phase.
    phase_e     m_phase;
    logic       m_player, m_paused, m_ts;
    int         m_aim_ticks, m_ticks;
    logic [4:0] f_hist;
    logic       prev_b1, prev_b2, prev_key;

    int   fc_cnt = 0;
    int   fc_period = 4;
    logic pol_busy = 1'b0;
    logic pol_noise = 1'b0;
    int   pause_burst = 0;

    function automatic logic [26:0] pack_out(input logic [7:0] k1, input logic [7:0] k2, input logic pl,
                                             input phase_e ph, input logic [5:0] s, input logic pa, input logic ts);
        logic [1:0] p;
        p = ph;
        return {k1, k2, pl, p, s, pa, ts};
    endfunction

    function automatic logic [26:0] model_out(input logic [7:0] k);
        logic open;
        open = (m_phase == AIM) && !m_paused;
        return pack_out((open && m_player == PLAYER_1) ? k : KEY_NONE,
                        (open && m_player == PLAYER_2) ? k : KEY_NONE,
                        m_player, m_phase, 6'(TURN - m_aim_ticks / FPS), m_paused, m_ts);
    endfunction

    function automatic logic [7:0] rand_key();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == KEY_PAUSE) v = 8'h04;
        return v;
    endfunction

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got kp1=%h kp2=%h pl=%0d ph=%0d sec=%0d pa=%0d ts=%0d, expected kp1=%h kp2=%h pl=%0d ph=%0d sec=%0d pa=%0d ts=%0d",
                     name, $time, act[26:19], act[18:11], act[10], act[9:8], act[7:2], act[1], act[0],
                     exp[26:19], exp[18:11], exp[10], exp[9:8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = AIM;
        m_player    = PLAYER_1;
        m_paused    = 1'b0;
        m_ts        = 1'b0;
        m_aim_ticks = 0;
        m_ticks     = 0;
        f_hist      = '0;
        prev_b1     = 1'b0;
        prev_b2     = 1'b0;
        prev_key    = 1'b0;
    endtask

    task automatic model_step();
        logic tk, b_act, b_prev, rise, fall, press;
        f_hist = {f_hist[3:0], frame_clk};
        tk     = f_hist[3] & ~f_hist[4];
        b_act  = (m_player == PLAYER_2) ? bomb_busy_p2 : bomb_busy_p1;
        b_prev = (m_player == PLAYER_2) ? prev_b2 : prev_b1;
        rise   = b_act & ~b_prev;
        fall   = ~b_act & b_prev;
        press  = (keycode == KEY_PAUSE) && !prev_key;
        m_ts   = 1'b0;
        case (m_phase)
            AIM: begin
                if (m_paused) begin
                    if (press) m_paused = 1'b0;
                end else begin
                    if (rise) begin
                        m_phase = FLIGHT;
                        m_ticks = 0;
                    end else if (tk) begin
                        m_aim_ticks++;
                        if (m_aim_ticks == TURN * FPS) begin
                            m_phase = SETTLE;
                            m_ticks = 0;
                        end
                    end
                    if (m_phase == AIM && press) m_paused = 1'b1;
                end
            end
            FLIGHT: begin
                if (fall) begin
                    m_phase = SETTLE;
                    m_ticks = 0;
                end else if (tk) begin
                    m_ticks++;
                    if (m_ticks == TIMEOUT) begin
                        m_phase = SETTLE;
                        m_ticks = 0;
                    end
                end
            end
            default: begin
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == SETTLE_F) begin
                        m_phase     = AIM;
                        m_player    = ~m_player;
                        m_aim_ticks = 0;
                        m_paused    = 1'b0;
                        m_ticks     = 0;
                        m_ts        = 1'b1;
                    end
                end
            end
        endcase
        prev_b1  = bomb_busy_p1;
        prev_b2  = bomb_busy_p2;
        prev_key = (keycode == KEY_PAUSE);
        if (m_ts) exp_ts++;
    endtask

    // Called at posedge+1; drives inputs, lets the DUT sample them, and queues the prediction.
    task automatic step(input logic [7:0] k, input logic b1, input logic b2);
        keycode      = k;
        bomb_busy_p1 = b1;
        bomb_busy_p2 = b2;
        fc_cnt++;
        if (fc_cnt >= fc_period) begin
            fc_cnt    = 0;
            fc_period = 4 + int'($urandom_range(0, 2));
        end
        frame_clk = (fc_cnt < 2);
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out(keycode));
        #1;
    endtask

    task automatic step_policy();
        logic [7:0] k;
        logic       b_in;
        if (pause_burst > 0) begin
            k = KEY_PAUSE;
            pause_burst--;
        end else begin
            k = rand_key();
        end
        b_in = pol_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (m_player == PLAYER_1) step(k, pol_busy, b_in);
        else                      step(k, b_in, pol_busy);
    endtask

    task automatic run_until(input phase_e target, input int budget);
        int n;
        n = 0;
        while (m_phase != target && n < budget) begin
            step_policy();
            n++;
        end
        vectors++;
        if (m_phase != target) begin
            miscompares++;
            $display("FAIL wait_phase: got phase %0d after %0d clk, expected phase %0d", m_phase, n, target);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        exp_q.delete();
        #1 check("async_reset", dut_vec, pack_out(KEY_NONE, KEY_NONE, PLAYER_1, AIM, 6'(TURN), 1'b0, 1'b0));
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("cycle", dut_vec, mon_exp);
            if (turn_start) begin
                ts_seen++;
                $display("turn_start: player %0d aims, t=%0t", active_player, $time);
            end
        end
    end

    initial begin
        model_reset();
        #4;
        do_reset();

        // Plain key pass-through to P1 right after reset.
        repeat (6) step(8'h04, 1'b0, 1'b0);

        // P1 launches, bomb lands, settle, hand over to P2 (P2 busy noise ignored).
        pol_noise = 1'b1;
        repeat (40) step_policy();
        pol_busy = 1'b1;
        run_until(FLIGHT, 50);
        repeat (30 + $urandom_range(0, 200)) step_policy();
        pol_busy = 1'b0;
        run_until(SETTLE, 10);
        run_until(AIM, 800);

        // P2 never launches: full countdown to zero, settle, back to P1.
        run_until(SETTLE, 12000);
        run_until(AIM, 800);

        // Pause held for many frames toggles once, freezes time; second press resumes.
        repeat (100) step_policy();
        repeat (50) step(KEY_PAUSE, 1'b0, 1'b0);
        repeat (600) step_policy();
        repeat (3) step(KEY_PAUSE, 1'b0, 1'b0);
        repeat (300) step_policy();

        // P1 bomb stuck high: flight ends only by timeout.
        pol_busy = 1'b1;
        run_until(FLIGHT, 20);
        run_until(SETTLE, 4500);
        pol_busy = 1'b0;
        run_until(AIM, 800);

        // P2 launches, reset strikes mid-flight with P2 busy still high.
        repeat (20) step_policy();
        pol_busy = 1'b1;
        run_until(FLIGHT, 20);
        repeat (50) step_policy();
        do_reset();
        repeat (100) step(rand_key(), 1'b0, 1'b1);

        // Random soak with launches, landings and pause bursts.
        pol_busy = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 59) == 0) pol_busy = ~pol_busy;
            if ($urandom_range(0, 299) == 0) pause_burst = 3;
            step_policy();
        end

        repeat (2) @(negedge clk);
        check_int("turn_start_count", ts_seen, exp_ts);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
